// File: rtl/bg_cmp_sched_if.sv
// Handshake and comparator-control bundle for the bandgap comparator scheduler.
// master: requester/comparator side; slave: the scheduler itself.
interface bg_cmp_sched_if #(
  parameter int unsigned NREQ = 4
) ();
  logic            pwrup;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            done;
  logic            result;
  logic            marginal;
  logic            busy;
  logic            CMPO;
  logic [1:0]      c1;
  logic [1:0]      c2;
  logic            cmpZeroOffset;
  logic            cmpSwapInput;

  modport master (
    output pwrup, req, CMPO,
    input  gnt, done, result, marginal, busy, c1, c2, cmpZeroOffset, cmpSwapInput
  );

  modport slave (
    input  pwrup, req, CMPO,
    output gnt, done, result, marginal, busy, c1, c2, cmpZeroOffset, cmpSwapInput
  );
endinterface

// File: rtl/bg_cmp_sched.sv
// Round-robin scheduler of the shared bandgap comparator (zero, phi1, phi2, compare).
// Define CHOP_EN for a second, input-swapped compare pass that produces the marginal flag.
module bg_cmp_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ZERO_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  bg_cmp_sched_if.slave  bus
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam logic [1:0] PH_OFF = 2'd0;
  localparam logic [1:0] PH_CMP = 2'd1;
  localparam logic [1:0] PH_SMP = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_PHI1,
    S_PHI2,
    S_CMP,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      c1_q, c1_d, c2_q, c2_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            result_q, result_d;
`ifdef CHOP_EN
  logic            pass_q, pass_d;
  logic            a_q, a_d;
  logic            swap_q, swap_d;
  logic            marginal_q, marginal_d;
`endif

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx_c;
  int unsigned     slot;

  // First requester at or after the rr pointer, wrapping NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    slot  = 0;
    idx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      slot = int'(ptr_q) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      idx_c = PW'(slot);
      if (!found && bus.req[idx_c]) begin
        found = 1'b1;
        pick  = idx_c;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    result_d = result_q;
`ifdef CHOP_EN
    pass_d     = pass_q;
    a_d        = a_q;
    marginal_d = marginal_q;
`endif

    if (!bus.pwrup) begin
      state_d = S_IDLE;
      gnt_d   = '0;
`ifdef CHOP_EN
      pass_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            state_d     = S_ZERO;
            gidx_d      = pick;
            gnt_d       = '0;
            gnt_d[pick] = 1'b1;
            cnt_d       = 4'(ZERO_CYC - 1);
`ifdef CHOP_EN
            pass_d      = 1'b0;
`endif
          end
        end
        S_ZERO: begin
          if (cnt_q == '0) state_d = S_PHI1;
          else             cnt_d   = cnt_q - 4'd1;
        end
        S_PHI1: state_d = S_PHI2;
        S_PHI2: begin
          state_d = S_CMP;
          cnt_d   = 4'(SETTLE_CYC - 1);
        end
        S_CMP: begin
          if (cnt_q == '0) begin
`ifdef CHOP_EN
            if (!pass_q) begin
              state_d = S_PHI1;
              pass_d  = 1'b1;
              a_d     = bus.CMPO;
            end else begin
              state_d    = S_DONE;
              result_d   = a_q;
              marginal_d = (a_q == bus.CMPO);
            end
`else
            state_d  = S_DONE;
            result_d = bus.CMPO;
`endif
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Control outputs are decoded from the next state so they are registered.
    c1_d   = PH_OFF;
    c2_d   = PH_OFF;
    zero_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_ZERO: begin
        zero_d = 1'b1;
        c1_d   = PH_SMP;
        c2_d   = PH_SMP;
      end
      S_PHI1: c1_d = PH_SMP;
      S_PHI2: c2_d = PH_SMP;
      S_CMP: begin
        c1_d = PH_CMP;
        c2_d = PH_CMP;
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
`ifdef CHOP_EN
    swap_d = pass_d && (state_d == S_PHI1 || state_d == S_PHI2 || state_d == S_CMP);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gidx_q     <= '0;
      gnt_q      <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      result_q   <= 1'b0;
`ifdef CHOP_EN
      pass_q     <= 1'b0;
      a_q        <= 1'b0;
      swap_q     <= 1'b0;
      marginal_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      gnt_q      <= gnt_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
`ifdef CHOP_EN
      pass_q     <= pass_d;
      a_q        <= a_d;
      swap_q     <= swap_d;
      marginal_q <= marginal_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.busy          = busy_q;
  assign bus.c1            = c1_q;
  assign bus.c2            = c2_q;
  assign bus.cmpZeroOffset = zero_q;
`ifdef CHOP_EN
  assign bus.cmpSwapInput  = swap_q;
  assign bus.marginal      = marginal_q;
`else
  assign bus.cmpSwapInput  = 1'b0;
  assign bus.marginal      = 1'b0;
`endif

endmodule

// File: tb/tb_bg_cmp_sched.sv
// Scoreboard bench for bg_cmp_sched: grant order, phase timeline, latency, abort and reset.
module tb_bg_cmp_sched;

  localparam int NREQ = 4;
  localparam int Z    = 2;
  localparam int S    = 2;
`ifdef CHOP_EN
  localparam bit CHOP = 1'b1;
  localparam int LAT  = Z + 2*S + 4;
`else
  localparam bit CHOP = 1'b0;
  localparam int LAT  = Z + S + 2;
`endif

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            result;
    logic            marginal;
    int              done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic cmpo_a = 1'b0;
  logic cmpo_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mptr = 0;
  exp_t exp_q[$];

  bg_cmp_sched_if #(.NREQ(NREQ)) bus ();

  bg_cmp_sched #(
    .NREQ      (NREQ),
    .ZERO_CYC  (Z),
    .SETTLE_CYC(S)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model: second (swapped) pass sees cmpo_b.
  always_comb bus.CMPO = bus.cmpSwapInput ? cmpo_b : cmpo_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (p + i) % NREQ;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  // {zero, c1, c2, swap} expected at a given cycle offset from the grant edge.
  function automatic logic [5:0] exp_phase(input int off);
    if (off < Z)         return {1'b1, 2'd2, 2'd2, 1'b0};
    if (off == Z)        return {1'b0, 2'd2, 2'd0, 1'b0};
    if (off == Z + 1)    return {1'b0, 2'd0, 2'd2, 1'b0};
    if (off < Z + 2 + S) return {1'b0, 2'd1, 2'd1, 1'b0};
    if (CHOP) begin
      if (off == Z + 2 + S)   return {1'b0, 2'd2, 2'd0, 1'b1};
      if (off == Z + 3 + S)   return {1'b0, 2'd0, 2'd2, 1'b1};
      if (off < Z + 2*S + 4)  return {1'b0, 2'd1, 2'd1, 1'b1};
    end
    return '0;
  endfunction

  // Monitor: phase timeline, one-hot grant, done against scoreboard.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    int              k_mon;
    exp_t            e;
    prev_gnt = '0;
    k_mon    = 0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
        if (bus.gnt != '0 && prev_gnt == '0) k_mon = cyc;
        if (bus.gnt != '0) begin
          chk("phase", {bus.cmpZeroOffset, bus.c1, bus.c2, bus.cmpSwapInput}, exp_phase(cyc - k_mon));
          chk("busy_hi", bus.busy, 1);
        end else begin
          chk("idle_ctl", {bus.cmpZeroOffset, bus.c1, bus.c2, bus.cmpSwapInput, bus.busy, bus.done}, 0);
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_gnt", bus.gnt, e.gnt);
            chk("result", bus.result, e.result);
            chk("marginal", bus.marginal, e.marginal);
            chk("done_cycle", cyc, e.done_cyc);
          end
        end
        prev_gnt = bus.gnt;
      end
    end
  end

  task automatic wait_gnt(output int k, output bit ok);
    ok = 1'b0;
    k  = cyc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (bus.gnt != '0) begin
        ok = 1'b1;
        k  = cyc;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(output int d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        d = cyc;
        return;
      end
    end
    chk("done_timeout", 0, 1);
    exp_q.delete();
    d = cyc;
  endtask

  task automatic wait_ctl(input logic [1:0] c1v, input logic [1:0] c2v);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (bus.c1 == c1v && bus.c2 == c2v) return;
    end
    chk("phase_timeout", 0, 1);
  endtask

  // Expected grant from the bench's own rr pointer; entry queued for the monitor.
  task automatic grant_and_push(input logic a, input logic b, output int k, output logic [NREQ-1:0] g);
    int              idx;
    bit              ok;
    logic [NREQ-1:0] eg;
    exp_t            e;
    idx = pick_rr(bus.req, mptr);
    eg  = '0;
    eg[idx] = 1'b1;
    e.gnt      = eg;
    e.result   = a;
    e.marginal = CHOP ? (a == b) : 1'b0;
    e.done_cyc = 0;
    exp_q.push_back(e);
    wait_gnt(k, ok);
    g = bus.gnt;
    if (ok) begin
      chk("gnt_rr", bus.gnt, eg);
      exp_q[exp_q.size()-1].done_cyc = k + LAT;
      mptr = (idx + 1) % NREQ;
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    int              k, d, prev_d;
    bit              ok;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    reset_n   = 1'b0;
    bus.pwrup = 1'b0;
    bus.req   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.gnt, bus.done, bus.result, bus.marginal, bus.busy,
                       bus.c1, bus.c2, bus.cmpZeroOffset, bus.cmpSwapInput}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single requester, CMPO=1.
    bus.pwrup = 1'b1;
    bus.req   = 4'b0010;
    cmpo_a = 1'b1; cmpo_b = 1'b1;
    grant_and_push(1'b1, 1'b1, k, g);
    chk("single_gnt", g, 4'b0010);
    wait_done(d);
    chk("latency", d - k, LAT);
    bus.req = '0;
    repeat (3) @(negedge clk);
    #1 chk("result_hold", bus.result, 1);

    // Async reset during compare phase.
    bus.req = 4'b1111;
    cmpo_a  = 1'b0;
    wait_gnt(k, ok);
    wait_ctl(2'd1, 2'd1);
    reset_n = 1'b0;
    #1 chk("async_rst", {bus.gnt, bus.done, bus.result, bus.marginal, bus.busy,
                         bus.c1, bus.c2, bus.cmpZeroOffset, bus.cmpSwapInput}, 0);
    bus.req = '0;
    mptr    = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("post_rst_idle", {bus.gnt, bus.busy}, 0);

    // All requesting, held: strict rr order and back-to-back spacing.
    bus.req = 4'b1111;
    prev_d  = 0;
    for (int n = 0; n < 5; n++) begin
      cmpo_a = n[0];
      cmpo_b = (n < 2) ? n[0] : ~n[0];
      grant_and_push(cmpo_a, cmpo_b, k, g);
      chk("rr_order", g, order[n]);
      if (n > 0) chk("b2b_gap", k - prev_d, 2);
      wait_done(d);
      prev_d = d;
    end
    bus.req = '0;

    // pwrup dropped during ZERO: abort, no done, same requester regranted.
    @(negedge clk);
    bus.req = 4'b0100;
    cmpo_a = 1'b1; cmpo_b = 1'b0;
    wait_gnt(k, ok);
    chk("pwr_first_gnt", bus.gnt, 4'b0100);
    bus.pwrup = 1'b0;
    @(negedge clk);
    #1 chk("pwr_abort", {bus.gnt, bus.busy, bus.c1, bus.c2, bus.cmpZeroOffset}, 0);
    repeat (3) @(negedge clk);
    #1 chk("pwr_block", bus.gnt, 0);
    bus.pwrup = 1'b1;
    grant_and_push(1'b1, 1'b0, k, g);
    chk("pwr_regrant", g, 4'b0100);
    wait_done(d);
    bus.req = '0;

    // Requester drops req in PHI2: sequence completes, pointer advances.
    @(negedge clk);
    bus.req = 4'b1001;
    cmpo_a = 1'b0; cmpo_b = 1'b0;
    grant_and_push(1'b0, 1'b0, k, g);
    chk("drop_gnt", g, 4'b1000);
    wait_ctl(2'd0, 2'd2);
    bus.req = '0;
    wait_done(d);
    @(negedge clk);
    #1 chk("drop_gnt_clr", bus.gnt, 0);
    bus.req = 4'b1111;
    cmpo_a = 1'b1; cmpo_b = 1'b1;
    grant_and_push(1'b1, 1'b1, k, g);
    chk("ptr_adv", g, 4'b0001);
    wait_done(d);
    bus.req = '0;

    repeat (4) @(negedge clk);
    #1 chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
